// File: rtl/fpga_top_mul_share_arb.sv
// -----------------------------------------------------------------------------
// fpga_top_mul_share_arb
// Round-robin arbiter that time-shares one unsigned 10x9 -> 14-bit truncating
// multiplier among NUM_REQ requesters of the CNN accelerator datapath.
// Results go out through a single registered port, tagged with the requester
// index, and the port honours downstream backpressure.
//
// Ports
//   ap_clk     clock, rising edge
//   ap_rst     synchronous reset, active-high
//   en         grant enable (0 blocks new grants, output still drains)
//   req_valid  per-requester operand valid            [NUM_REQ]
//   req_a      packed operand A, 10 bits per requester [NUM_REQ*10]
//   req_b      packed operand B, 9 bits per requester  [NUM_REQ*9]
//   req_ready  one-hot (or zero) grant, combinational  [NUM_REQ]
//   res_valid  result valid (registered)
//   res_ready  downstream accepts result
//   res_data   truncated product (registered)          [14]
//   res_id     index of producing requester (registered) [ID_W]
//   op_count   results accepted downstream since reset [CNT_W]
// -----------------------------------------------------------------------------
module fpga_top_mul_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*10-1:0]  req_a,
  input  logic [NUM_REQ*9-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [13:0]            res_data,
  output logic [ID_W-1:0]        res_id,
  output logic [CNT_W-1:0]       op_count
);

  localparam int unsigned A_W = 10;
  localparam int unsigned B_W = 9;
  localparam int unsigned P_W = A_W + B_W;
  localparam int unsigned R_W = 14;

  // Round-robin scan starting at ptr; returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    int unsigned     s;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      s    = (32'(ptr) + k) % NUM_REQ;
      cand = ID_W'(s);
      if (!found && v[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Unpack per-requester operands.
  logic [A_W-1:0] a_arr [NUM_REQ];
  logic [B_W-1:0] b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*A_W +: A_W];
    assign b_arr[gi] = req_b[gi*B_W +: B_W];
  end

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W:0]    pick_c;
  logic             grant_found_c;
  logic [ID_W-1:0]  grant_idx_c;
  logic             can_accept_c;
  logic             xfer_c;
  logic             drain_c;
  logic [A_W-1:0]   a_sel_c;
  logic [B_W-1:0]   b_sel_c;
  logic [R_W-1:0]   prod_c;

  logic             res_valid_d;
  logic [R_W-1:0]   res_data_d;
  logic [ID_W-1:0]  res_id_d;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [CNT_W-1:0] op_count_d;

  // Arbitration and grant; reset cycle never grants.
  always_comb begin
    pick_c        = rr_pick(req_valid, rr_ptr);
    grant_found_c = pick_c[ID_W];
    grant_idx_c   = pick_c[ID_W-1:0];
    can_accept_c  = !res_valid || res_ready;
    xfer_c        = en && can_accept_c && grant_found_c && !ap_rst;
    drain_c       = res_valid && res_ready;
    req_ready     = '0;
    if (xfer_c) begin
      req_ready[grant_idx_c] = 1'b1;
    end
  end

  // Shared multiplier: full 19-bit product, low 14 bits kept.
  always_comb begin
    a_sel_c = a_arr[grant_idx_c];
    b_sel_c = b_arr[grant_idx_c];
    prod_c  = R_W'(P_W'(a_sel_c) * P_W'(b_sel_c));
  end

  // Next state of the output register, pointer and counter.
  always_comb begin
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_id_d    = res_id;
    rr_ptr_d    = rr_ptr;
    op_count_d  = op_count;
    if (drain_c) begin
      res_valid_d = 1'b0;
      op_count_d  = op_count + CNT_W'(1);
    end
    // A new transfer reloads the register even while it drains.
    if (xfer_c) begin
      res_valid_d = 1'b1;
      res_data_d  = prod_c;
      res_id_d    = grant_idx_c;
      if (32'(grant_idx_c) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_c + ID_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
      op_count  <= '0;
    end else begin
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_id    <= res_id_d;
      rr_ptr    <= rr_ptr_d;
      op_count  <= op_count_d;
    end
  end

endmodule

// File: tb/tb_fpga_top_mul_share_arb.sv
// -----------------------------------------------------------------------------
// tb_fpga_top_mul_share_arb
// Directed self-checking bench: expected results are queued when a grant is
// made and compared when the result handshakes out.
// -----------------------------------------------------------------------------
module tb_fpga_top_mul_share_arb;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [39:0] req_a;
  logic [35:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [13:0] res_data;
  logic [1:0]  res_id;
  logic [31:0] op_count;

  typedef struct packed {
    logic [1:0]  id;
    logic [13:0] data;
  } sb_t;

  sb_t         sb[$];
  int          a_in[4];
  int          b_in[4];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;

  fpga_top_mul_share_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(32)) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .en       (en),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_id   (res_id),
    .op_count (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [13:0] mul14(input int a, input int b);
    int p;
    p = a * b;
    return 14'(p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    req_a = {10'(a_in[3]), 10'(a_in[2]), 10'(a_in[1]), 10'(a_in[0])};
    req_b = {9'(b_in[3]), 9'(b_in[2]), 9'(b_in[1]), 9'(b_in[0])};
  endtask

  // One clock: drive, check grant and output against the scoreboard, clock.
  task automatic step(input logic [3:0] v, input logic rdy, input logic e,
                      input logic [3:0] exp_rdy);
    sb_t exp;
    int  g;
    req_valid = v;
    res_ready = rdy;
    en        = e;
    drive_ops();
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      exp = sb[0];
      chk("res_id", 32'(res_id), 32'(exp.id));
      chk("res_data", 32'(res_data), 32'(exp.data));
      if (rdy) begin
        void'(sb.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
    end
    if (exp_rdy != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) g = i;
      exp.id   = 2'(g);
      exp.data = mul14(a_in[g], b_in[g]);
      sb.push_back(exp);
    end
    @(posedge ap_clk);
    #1;
    chk("op_count", op_count, exp_cnt);
  endtask

  // Reset with requests present and the output stalled.
  task automatic do_reset();
    ap_rst    = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b0;
    en        = 1'b1;
    drive_ops();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    sb.delete();
    exp_cnt = '0;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_op_count", op_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      a_in[i] = 0;
      b_in[i] = 0;
    end
    ap_rst    = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    drive_ops();
    @(posedge ap_clk);
    #1;
    do_reset();

    // Single requester 2: 3*5 = 15.
    a_in[2] = 3; b_in[2] = 5;
    step(4'b0100, 1'b1, 1'b1, 4'b0100);
    chk("single_data", 32'(res_data), 32'd15);
    step(4'b0000, 1'b1, 1'b1, 4'b0000);
    chk("single_cnt", op_count, 32'd1);

    // Truncation: 1023*511 -> 0x3A01, 128*128 -> 0 (pointer now 3).
    a_in[0] = 1023; b_in[0] = 511;
    a_in[1] = 128;  b_in[1] = 128;
    step(4'b0001, 1'b1, 1'b1, 4'b0001);
    chk("trunc_max", 32'(res_data), 32'h3A01);
    step(4'b0010, 1'b1, 1'b1, 4'b0010);
    chk("trunc_wrap", 32'(res_data), 32'd0);
    step(4'b0000, 1'b1, 1'b1, 4'b0000);

    // Fairness from pointer 0 with all requesters valid.
    do_reset();
    a_in[0] = 7;   b_in[0] = 9;
    a_in[1] = 100; b_in[1] = 200;
    a_in[2] = 555; b_in[2] = 300;
    a_in[3] = 1000; b_in[3] = 17;
    for (int r = 0; r < 2; r++) begin
      step(4'hF, 1'b1, 1'b1, 4'b0001);
      step(4'hF, 1'b1, 1'b1, 4'b0010);
      step(4'hF, 1'b1, 1'b1, 4'b0100);
      step(4'hF, 1'b1, 1'b1, 4'b1000);
    end
    step(4'h0, 1'b1, 1'b1, 4'b0000);
    chk("fair_cnt", op_count, 32'd8);

    // Backpressure with id 1 pending, then release grants requester 2.
    step(4'b0010, 1'b1, 1'b1, 4'b0010);
    for (int s = 0; s < 3; s++) step(4'b1101, 1'b0, 1'b1, 4'b0000);
    chk("bp_hold_id", 32'(res_id), 32'd1);
    step(4'b1101, 1'b1, 1'b1, 4'b0100);
    chk("bp_next_id", 32'(res_id), 32'd2);
    step(4'b0000, 1'b1, 1'b1, 4'b0000);

    // en=0: pending result drains, no grants; en=1 resumes at pointer 0.
    step(4'hF, 1'b1, 1'b1, 4'b1000);
    step(4'hF, 1'b1, 1'b0, 4'b0000);
    step(4'hF, 1'b1, 1'b0, 4'b0000);
    chk("en_drained", 32'(res_valid), 32'd0);
    step(4'hF, 1'b1, 1'b1, 4'b0001);

    // Reset while stalled: result dropped, counter cleared.
    step(4'hF, 1'b0, 1'b1, 4'b0000);
    do_reset();
    step(4'b0110, 1'b1, 1'b1, 4'b0010);
    step(4'b0000, 1'b1, 1'b1, 4'b0000);
    chk("post_rst_cnt", op_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_top_mul_share_arb.md
Name: fpga_top_mul_share_arb

Overview:
- Round-robin arbiter that time-shares one unsigned 10-bit x 9-bit -> 14-bit truncating multiplier among NUM_REQ requesters in the CNN accelerator datapath.
- Each requester presents an operand pair with a valid/ready handshake.
- Granted pairs are multiplied and returned through a single registered result port, tagged with the requester index, with downstream backpressure.
- Sits between the conv/FC compute loops and the shared DSP multiply resource.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of requester tag; must equal clog2(NUM_REQ).
- CNT_W, 32: width of the completed-operation counter.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- en  in  1  grant enable; 0 blocks new grants while the output still drains.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*10  packed operand A; requester i uses bits [i*10+9:i*10], unsigned.
- req_b  in  NUM_REQ*9  packed operand B; requester i uses bits [i*9+8:i*9], unsigned.
- req_ready  out  NUM_REQ  one-hot (or zero) grant/accept.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  14  product, truncated.
- res_id  out  ID_W  index of the requester that produced res_data.
- op_count  out  CNT_W  number of results accepted downstream since reset.

Behaviour:
- Reset (ap_rst=1 at a clock edge): res_valid=0, res_data=0, res_id=0, rr_ptr=0, op_count=0.
  - Any held result is discarded.
  - req_ready is 0 throughout the reset cycle.
- can_accept = !res_valid || res_ready (output register empty, or emptying this cycle).
- Arbitration is combinational:
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - g is the first index with req_valid set.
  - req_ready[g]=1 only when en && can_accept && a valid request exists. All other bits are 0.
  - req_ready may depend on req_valid.
  - Requesters must hold valid and operands stable until accepted.
- Transfer: when req_valid[g] && req_ready[g] at an edge:
  - res_data <= (a_g * b_g) mod 2^14. The full 19-bit product is formed, then bits [13:0] are kept with no saturation.
  - res_id <= g.
  - res_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: result is visible the cycle after acceptance, i.e. 1 cycle.
- Throughput: one operation per cycle when res_ready is held at 1.
- Output handshake: when res_valid && res_ready at an edge:
  - op_count increments, wrapping at 2^CNT_W to 0.
  - If there is no simultaneous new transfer, res_valid <= 0.
  - If there is a simultaneous new transfer, the register is reloaded and res_valid stays 1 (back-to-back operation).
- Backpressure: while res_valid && !res_ready:
  - res_data and res_id hold stable.
  - All req_ready bits are 0.
  - rr_ptr holds.
- No valid requests: rr_ptr holds and nothing changes.
- en=0: no grants and rr_ptr holds. The pending result still completes its handshake. Raising en resumes from the held rr_ptr.
- Fairness: with all requesters continuously valid and res_ready=1, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Reset mid-operation (res_valid=1, stalled): the result is dropped and op_count does not increment.

Test Plan:
- Single requester, with req 2 valid, a=3, b=5, res_ready=1 -> req_ready=0b0100 in the request cycle; next cycle res_valid=1, res_data=15, res_id=2; op_count=1 after the handshake.
- Truncation: a=1023, b=511 -> res_data=0x3A01 (full product 0x7FA01). a=128, b=128 -> res_data=0 (16384 mod 2^14).
- All 4 requesters continuously valid, res_ready=1, for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3, one result per cycle; op_count=8.
- Backpressure: hold res_ready=0 for 3 cycles with result id=1 pending and others valid -> res_data/res_id unchanged, req_ready=0. On release, the next grant is requester 2.
- en=0 with requests pending and result valid -> the result drains, then no new grants. en=1 -> grants resume from rr_ptr.
- Assert ap_rst with res_valid=1 and res_ready=0 -> next cycle res_valid=0, res_id=0, op_count=0, and the first grant after reset goes to the lowest valid index ≥0.
